// File: rtl/fc_classifier_if.sv
// Feature-stream and result-stream signals of the fc classifier stage.
// The master side feeds features/weights and consumes the result; the
// slave side is the classifier itself.
interface fc_classifier_if #(
    parameter int DATA_W   = 32,
    parameter int WEIGHT_W = 32,
    parameter int ACC_W    = 72,
    parameter int N_CLASS  = 10,
    parameter int IDX_W    = $clog2(N_CLASS)
);
    logic                          feat_valid;
    logic                          feat_ready;
    logic signed [DATA_W-1:0]      feat_data;
    logic [N_CLASS*WEIGHT_W-1:0]   w_data;
    logic                          result_valid;
    logic                          result_ready;
    logic [IDX_W-1:0]              result;
    logic signed [ACC_W-1:0]       max_score;
    logic                          sat_flag;

    modport master (
        output feat_valid, feat_data, w_data, result_ready,
        input  feat_ready, result_valid, result, max_score, sat_flag
    );

    modport slave (
        input  feat_valid, feat_data, w_data, result_ready,
        output feat_ready, result_valid, result, max_score, sat_flag
    );
endinterface

// File: rtl/fc_classifier.sv
// Streaming fully-connected classifier: accumulates one signed score per
// class over N_FEAT feature beats with saturating adds, then scans the
// scores one class per cycle and presents the argmax index and its score.
module fc_classifier #(
    parameter int DATA_W   = 32,
    parameter int WEIGHT_W = 32,
    parameter int ACC_W    = 72,
    parameter int N_FEAT   = 1152,
    parameter int N_CLASS  = 10,
    parameter int IDX_W    = $clog2(N_CLASS)
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic clear,
    output logic busy,
    fc_classifier_if.slave bus
);
    // ACC_W must be at least DATA_W+WEIGHT_W so a product always fits.
    localparam int PROD_W = DATA_W + WEIGHT_W;
    localparam int CNT_W  = $clog2(N_FEAT + 1);
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACCUM, SCAN, DONE} state_t;

    state_t                  state;
    logic signed [ACC_W-1:0] acc      [N_CLASS];
    logic signed [ACC_W-1:0] acc_next [N_CLASS];
    logic [N_CLASS-1:0]      clamp;
    logic [CNT_W-1:0]        feat_cnt;
    logic [IDX_W-1:0]        scan_idx;
    logic [IDX_W-1:0]        best_idx;
    logic [IDX_W-1:0]        win_idx;
    logic signed [ACC_W-1:0] best_score;
    logic signed [ACC_W-1:0] win_score;
    logic signed [ACC_W-1:0] scan_score;
    logic                    beat;

    assign beat = bus.feat_valid && bus.feat_ready;

    // Per-class product and saturating add; one extra sum bit exposes overflow
    always_comb begin
        logic signed [WEIGHT_W-1:0] w_k;
        logic signed [PROD_W-1:0]   prod;
        logic [ACC_W:0]             sum;
        w_k   = '0;
        prod  = '0;
        sum   = '0;
        clamp = '0;
        for (int k = 0; k < N_CLASS; k++) begin
            w_k  = bus.w_data[k*WEIGHT_W +: WEIGHT_W];
            prod = bus.feat_data * w_k;
            sum  = {acc[k][ACC_W-1], acc[k]}
                 + {{(ACC_W+1-PROD_W){prod[PROD_W-1]}}, prod};
            clamp[k] = (sum[ACC_W] != sum[ACC_W-1]);
            if (clamp[k]) begin
                acc_next[k] = sum[ACC_W] ? ACC_MIN : ACC_MAX;
            end else begin
                acc_next[k] = sum[ACC_W-1:0];
            end
        end
    end

    // Running argmax: index 0 always loads, later ones only if strictly greater
    always_comb begin
        scan_score = acc[scan_idx];
        win_score  = best_score;
        win_idx    = best_idx;
        if (scan_idx == '0 || scan_score > best_score) begin
            win_score = scan_score;
            win_idx   = scan_idx;
        end
    end

    // Control FSM with registered handshake and result outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= IDLE;
            for (int k = 0; k < N_CLASS; k++) acc[k] <= '0;
            feat_cnt         <= '0;
            scan_idx         <= '0;
            best_idx         <= '0;
            best_score       <= '0;
            busy             <= 1'b0;
            bus.feat_ready   <= 1'b0;
            bus.result_valid <= 1'b0;
            bus.result       <= '0;
            bus.max_score    <= '0;
            bus.sat_flag     <= 1'b0;
        end else if (clear) begin
            state            <= IDLE;
            for (int k = 0; k < N_CLASS; k++) acc[k] <= '0;
            feat_cnt         <= '0;
            busy             <= 1'b0;
            bus.feat_ready   <= 1'b0;
            bus.result_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        for (int k = 0; k < N_CLASS; k++) acc[k] <= '0;
                        feat_cnt       <= '0;
                        bus.sat_flag   <= 1'b0;
                        bus.feat_ready <= 1'b1;
                        busy           <= 1'b1;
                        state          <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (beat) begin
                        for (int k = 0; k < N_CLASS; k++) acc[k] <= acc_next[k];
                        if (|clamp) bus.sat_flag <= 1'b1;
                        if (feat_cnt == CNT_W'(N_FEAT - 1)) begin
                            bus.feat_ready <= 1'b0;
                            scan_idx       <= '0;
                            state          <= SCAN;
                        end else begin
                            feat_cnt <= feat_cnt + CNT_W'(1);
                        end
                    end
                end
                SCAN: begin
                    best_score <= win_score;
                    best_idx   <= win_idx;
                    if (scan_idx == IDX_W'(N_CLASS - 1)) begin
                        bus.result       <= win_idx;
                        bus.max_score    <= win_score;
                        bus.result_valid <= 1'b1;
                        state            <= DONE;
                    end else begin
                        scan_idx <= scan_idx + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (bus.result_ready) begin
                        bus.result_valid <= 1'b0;
                        busy             <= 1'b0;
                        state            <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fc_classifier.sv
// Directed bench for fc_classifier: two instances share the same stimulus,
// one with a 20-bit accumulator and one with a 16-bit accumulator used for
// the saturation cases. Expected values are hand-computed in the table.
module tb_fc_classifier;
    localparam int N_CLASS = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              clear;
    logic              feat_valid;
    logic              result_ready;
    logic signed [7:0] feat_data;
    logic [23:0]       w_data;
    logic              busy_a;
    logic              busy_b;
    logic              use16;

    logic              obs_ready;
    logic              obs_rvalid;
    logic              obs_sat;
    logic              obs_busy;
    logic [1:0]        obs_result;
    logic signed [19:0] obs_score;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fc_classifier_if #(.DATA_W(8), .WEIGHT_W(8), .ACC_W(20), .N_CLASS(3), .IDX_W(2)) bus_a ();
    fc_classifier_if #(.DATA_W(8), .WEIGHT_W(8), .ACC_W(16), .N_CLASS(3), .IDX_W(2)) bus_b ();

    assign bus_a.feat_valid   = feat_valid;
    assign bus_a.feat_data    = feat_data;
    assign bus_a.w_data       = w_data;
    assign bus_a.result_ready = result_ready;
    assign bus_b.feat_valid   = feat_valid;
    assign bus_b.feat_data    = feat_data;
    assign bus_b.w_data       = w_data;
    assign bus_b.result_ready = result_ready;

    fc_classifier #(.DATA_W(8), .WEIGHT_W(8), .ACC_W(20), .N_FEAT(4), .N_CLASS(3), .IDX_W(2)) dut_a (
        .clk(clk), .rst(rst), .start(start), .clear(clear), .busy(busy_a), .bus(bus_a)
    );

    fc_classifier #(.DATA_W(8), .WEIGHT_W(8), .ACC_W(16), .N_FEAT(4), .N_CLASS(3), .IDX_W(2)) dut_b (
        .clk(clk), .rst(rst), .start(start), .clear(clear), .busy(busy_b), .bus(bus_b)
    );

    // Select which instance is observed
    always_comb begin
        if (use16) begin
            obs_ready  = bus_b.feat_ready;
            obs_rvalid = bus_b.result_valid;
            obs_sat    = bus_b.sat_flag;
            obs_busy   = busy_b;
            obs_result = bus_b.result;
            obs_score  = {{4{bus_b.max_score[15]}}, bus_b.max_score};
        end else begin
            obs_ready  = bus_a.feat_ready;
            obs_rvalid = bus_a.result_valid;
            obs_sat    = bus_a.sat_flag;
            obs_busy   = busy_a;
            obs_result = bus_a.result;
            obs_score  = bus_a.max_score;
        end
    end

    typedef struct packed {
        logic [3:0][7:0]  f;
        logic [3:0][23:0] w;
        logic [1:0]       exp_result;
        logic [19:0]      exp_score;
        logic             exp_sat;
        logic             use16;
    } vec_t;

    vec_t vecs [7];

    function automatic vec_t mk(input int f[4], input int c0[4], input int c1[4], input int c2[4],
                                input int r, input int s, input bit sat, input bit u16);
        vec_t v;
        v = '0;
        for (int i = 0; i < 4; i++) begin
            v.f[i] = 8'(f[i]);
            v.w[i] = {8'(c2[i]), 8'(c1[i]), 8'(c0[i])};
        end
        v.exp_result = 2'(r);
        v.exp_score  = 20'(s);
        v.exp_sat    = sat;
        v.use16      = u16;
        return v;
    endfunction

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
        end
    endtask

    // Pulse start; on return busy and feat_ready must already be high
    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_output("busy after start", int'(obs_busy), 1);
        check_output("feat_ready after start", int'(obs_ready), 1);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic apply_stimulus(input logic [7:0] d, input logic [23:0] w, input int gaps);
        int guard;
        if (gaps > 0) begin
            feat_valid = 1'b0;
            repeat (gaps) @(negedge clk);
        end
        feat_valid = 1'b1;
        feat_data  = d;
        w_data     = w;
        guard      = 0;
        while (!obs_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) check_output("feat_ready wait", 0, 1);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called at the negedge after the last beat; waits for and checks the result
    task automatic collect(input vec_t v, input bit flood);
        int lat;
        if (flood) begin
            feat_valid = 1'b1;
            feat_data  = 8'sd100;
            w_data     = {8'sd100, 8'sd100, 8'sd100};
        end else begin
            feat_valid = 1'b0;
        end
        check_output("feat_ready after last beat", int'(obs_ready), 0);
        lat = 0;
        while (!obs_rvalid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        // Result appears in cycle L+N_CLASS+1, i.e. N_CLASS edges after beat edge L
        check_output("result latency", lat, N_CLASS);
        check_output("result", int'(obs_result), int'(v.exp_result));
        check_output("max_score", int'(obs_score), int'($signed(v.exp_score)));
        check_output("sat_flag", int'(obs_sat), int'(v.exp_sat));
        feat_valid = 1'b0;
    endtask

    task automatic finish_result();
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        check_output("result_valid after handshake", int'(obs_rvalid), 0);
        check_output("busy after handshake", int'(obs_busy), 0);
    endtask

    task automatic run_to_done(input vec_t v, input bit gaps, input bit flood);
        use16 = v.use16;
        do_start();
        for (int i = 0; i < 4; i++)
            apply_stimulus(v.f[i], v.w[i], gaps ? int'($urandom_range(0, 2)) : 0);
        collect(v, flood);
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, " result_valid"}, int'(obs_rvalid), 0);
        check_output({tag, " feat_ready"}, int'(obs_ready), 0);
        check_output({tag, " busy"}, int'(obs_busy), 0);
        check_output({tag, " result"}, int'(obs_result), 0);
        check_output({tag, " max_score"}, int'(obs_score), 0);
        check_output({tag, " sat_flag"}, int'(obs_sat), 0);
    endtask

    // Absolute time bound so the bench can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int stable;
        vecs[0] = mk('{1,2,3,4}, '{1,1,1,1}, '{0,0,0,5}, '{-1,-1,-1,-1}, 1, 20, 1'b0, 1'b0);
        vecs[1] = mk('{1,2,3,4}, '{0,0,0,5}, '{0,0,0,1}, '{0,0,0,5}, 0, 20, 1'b0, 1'b0);
        vecs[2] = mk('{1,2,3,4}, '{-3,0,0,0}, '{-1,0,0,0}, '{-1,-1,0,-1}, 1, -1, 1'b0, 1'b0);
        vecs[3] = mk('{127,127,127,127}, '{127,127,127,127}, '{0,0,0,0}, '{0,0,0,0}, 0, 32767, 1'b1, 1'b1);
        vecs[4] = mk('{1,2,3,4}, '{1,1,1,1}, '{0,0,0,5}, '{-1,-1,-1,-1}, 1, 20, 1'b0, 1'b1);
        vecs[5] = mk('{-128,-128,-128,-128}, '{127,127,127,127}, '{1,1,1,1}, '{-1,-1,-1,-1}, 2, 512, 1'b1, 1'b1);
        vecs[6] = mk('{127,127,127,-128}, '{127,127,127,127}, '{0,0,0,0}, '{0,0,0,0}, 0, 16511, 1'b1, 1'b1);

        rst = 1'b0; start = 1'b0; clear = 1'b0; feat_valid = 1'b0;
        result_ready = 1'b0; feat_data = '0; w_data = '0; use16 = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b1;

        // Table-driven inferences
        for (int i = 0; i < 7; i++) begin
            run_to_done(vecs[i], 1'b0, 1'b0);
            finish_result();
        end

        // Random gaps and extra beats offered after the last one
        run_to_done(vecs[0], 1'b1, 1'b1);
        finish_result();

        // Result held stable under result_ready low
        run_to_done(vecs[0], 1'b0, 1'b0);
        stable = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (obs_rvalid && obs_result == 2'd1 && obs_score == 20'sd20) stable++;
        end
        check_output("hold stable cycles", stable, 10);
        finish_result();

        // clear after two beats, then a fresh basic run
        use16 = 1'b0;
        do_start();
        apply_stimulus(vecs[0].f[0], vecs[0].w[0], 0);
        apply_stimulus(vecs[0].f[1], vecs[0].w[1], 0);
        feat_valid = 1'b0;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check_output("busy after clear", int'(obs_busy), 0);
        check_output("feat_ready after clear", int'(obs_ready), 0);
        run_to_done(vecs[0], 1'b0, 1'b0);
        finish_result();

        // Reset asserted during SCAN
        do_start();
        for (int i = 0; i < 4; i++) apply_stimulus(vecs[0].f[i], vecs[0].w[i], 0);
        feat_valid = 1'b0;
        rst = 1'b0;
        #1;
        check_reset_values("rst in scan");
        @(negedge clk);
        check_reset_values("rst held");
        rst = 1'b1;

        // start during ACCUM is ignored: counter and accumulators keep going
        do_start();
        apply_stimulus(vecs[1].f[0], vecs[1].w[0], 0);
        apply_stimulus(vecs[1].f[1], vecs[1].w[1], 0);
        feat_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        apply_stimulus(vecs[1].f[2], vecs[1].w[2], 0);
        apply_stimulus(vecs[1].f[3], vecs[1].w[3], 0);
        collect(vecs[1], 1'b0);

        // start during DONE is ignored
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_output("start in DONE result_valid", int'(obs_rvalid), 1);
        check_output("start in DONE busy", int'(obs_busy), 1);
        check_output("start in DONE result", int'(obs_result), 0);

        // start on the handshake cycle is ignored, one cycle later accepted
        start = 1'b1;
        result_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        result_ready = 1'b0;
        check_output("start on handshake busy", int'(obs_busy), 0);
        check_output("start on handshake feat_ready", int'(obs_ready), 0);
        do_start();
        for (int i = 0; i < 4; i++) apply_stimulus(vecs[0].f[i], vecs[0].w[i], 0);
        collect(vecs[0], 1'b0);
        finish_result();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
